// File: rtl/ifq_pkg.sv
// Shared constants for the instruction fetch queue.
// NOP is the canonical RV32I "addi x0, x0, 0" that is presented when the queue is empty.
package ifq_pkg;

    localparam int unsigned IFQ_DEPTH_DEF = 4;
    localparam int unsigned IFQ_XLEN_DEF  = 32;
    localparam logic [31:0] NOP           = 32'h0000_0013;

endpackage : ifq_pkg

// File: rtl/ifq_if.sv
// Fetch-side and execute-side handshake bundle of the instruction fetch queue.
// The slave modport is the queue itself; the master modport is its environment.
interface ifq_if #(
    parameter int unsigned XLEN = 32
);

    logic            in_valid_i;
    logic [XLEN-1:0] in_pc_i;
    logic [XLEN-1:0] in_instr_i;
    logic            in_ready_o;

    logic            out_valid_o;
    logic [XLEN-1:0] out_pc_o;
    logic [XLEN-1:0] out_instr_o;
    logic            out_ready_i;
    logic            out_illegal_o;

    modport slave (
        input  in_valid_i, in_pc_i, in_instr_i, out_ready_i,
        output in_ready_o, out_valid_o, out_pc_o, out_instr_o, out_illegal_o
    );

    modport master (
        output in_valid_i, in_pc_i, in_instr_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_pc_o, out_instr_o, out_illegal_o
    );

endinterface : ifq_if

// File: rtl/ifq_ptr_ctrl.sv
// Read/write pointers, occupancy count and full/empty flags of the fetch queue.
// A flush wins over any push or pop presented in the same cycle.
module ifq_ptr_ctrl #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH),
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_req_i,
    input  logic             pop_req_i,
    output logic             push_o,
    output logic             pop_o,
    output logic [PTR_W-1:0] wr_ptr_o,
    output logic [PTR_W-1:0] rd_ptr_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             full, empty, push, pop;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        full     = (count_q == CNT_W'(DEPTH));
        empty    = (count_q == '0);
        push     = push_req_i & ~full & ~flush_i;
        pop      = pop_req_i & ~empty & ~flush_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are exactly log2(DEPTH) wide, so the increment wraps on its own.
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign push_o   = push;
    assign pop_o    = pop;
    assign wr_ptr_o = wr_ptr_q;
    assign rd_ptr_o = rd_ptr_q;
    assign count_o  = count_q;
    assign full_o   = full;
    assign empty_o  = empty;

endmodule : ifq_ptr_ctrl

// File: rtl/ifq.sv
// Instruction fetch queue: buffers SRAM-returned (PC, instr) pairs for the execute unit.
// Optional per-entry illegal-encoding flag enabled by defining IFQ_ILLEGAL_CHECK_EN.
module ifq
    import ifq_pkg::*;
#(
    parameter int unsigned DEPTH = IFQ_DEPTH_DEF,
    parameter int unsigned XLEN  = IFQ_XLEN_DEF,
    parameter int unsigned PTR_W = $clog2(DEPTH),
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    ifq_if.slave             bus,
    output logic [CNT_W-1:0] count_o
);

    logic             push, pop, full, empty;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;

    logic [XLEN-1:0]  pc_mem    [DEPTH];
    logic [XLEN-1:0]  instr_mem [DEPTH];
    logic [XLEN-1:0]  last_pc_q, last_pc_d;
    logic [XLEN-1:0]  head_pc;

    ifq_ptr_ctrl #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .CNT_W (CNT_W)
    ) u_ptr_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush_i),
        .push_req_i (bus.in_valid_i),
        .pop_req_i  (bus.out_ready_i),
        .push_o     (push),
        .pop_o      (pop),
        .wr_ptr_o   (wr_ptr),
        .rd_ptr_o   (rd_ptr),
        .count_o    (count_o),
        .full_o     (full),
        .empty_o    (empty)
    );

    // NOTE: storage is not reset; an entry is only ever read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= bus.in_pc_i;
            instr_mem[wr_ptr] <= bus.in_instr_i;
        end
    end

`ifdef IFQ_ILLEGAL_CHECK_EN
    logic ill_mem [DEPTH];

    // A word whose low two bits are not 2'b11 is not a 32-bit RV32I encoding.
    always_ff @(posedge clk) begin
        if (push) begin
            ill_mem[wr_ptr] <= (bus.in_instr_i[1:0] != 2'b11);
        end
    end

    assign bus.out_illegal_o = ~empty & ill_mem[rd_ptr];
`else
    assign bus.out_illegal_o = 1'b0;
`endif

    // The head PC is remembered every cycle so an empty queue keeps showing the last one.
    always_comb begin
        head_pc   = empty ? last_pc_q : pc_mem[rd_ptr];
        last_pc_d = head_pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_pc_q <= '0;
        end else begin
            last_pc_q <= last_pc_d;
        end
    end

    assign bus.in_ready_o  = ~full;
    assign bus.out_valid_o = ~empty;
    assign bus.out_pc_o    = head_pc;
    assign bus.out_instr_o = empty ? XLEN'(NOP) : instr_mem[rd_ptr];

    logic unused_pop;
    assign unused_pop = pop;

endmodule : ifq

// File: tb/tb_ifq.sv
// Directed self-checking bench for the instruction fetch queue (DEPTH=4, XLEN=32).
module tb_ifq;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;
    localparam logic [31:0] NOP   = 32'h0000_0013;

`ifdef IFQ_ILLEGAL_CHECK_EN
    localparam logic ILL_EXP = 1'b1;
`else
    localparam logic ILL_EXP = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       flush_i;
    logic [2:0] count_o;

    int n_cmp;
    int n_err;

    ifq_if #(.XLEN(XLEN)) bus ();

    ifq #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush_i),
        .bus     (bus),
        .count_o (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                         input logic rdy);
        bus.in_valid_i  = v;
        bus.in_pc_i     = pc;
        bus.in_instr_i  = instr;
        bus.out_ready_i = rdy;
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        flush_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        #12;
        check("rst_count",   32'(count_o),          32'd0);
        check("rst_valid",   32'(bus.out_valid_o),  32'd0);
        check("rst_pc",      bus.out_pc_o,          32'h0);
        check("rst_instr",   bus.out_instr_o,       NOP);
        check("rst_illegal", 32'(bus.out_illegal_o), 32'd0);
        check("rst_ready",   32'(bus.in_ready_o),   32'd1);
        #2 rst_n = 1'b1;
        tick();

        // Three pushes held at the head, then drained in order.
        drive(1'b1, 32'h0, 32'h0010_0093, 1'b0);
        tick();
        check("t1_first_pc",    bus.out_pc_o,         32'h0);
        check("t1_first_valid", 32'(bus.out_valid_o), 32'd1);
        drive(1'b1, 32'h4, 32'h0020_0113, 1'b0);
        tick();
        drive(1'b1, 32'h8, 32'h0030_0193, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        check("t1_count3", 32'(count_o), 32'd3);
        bus.out_ready_i = 1'b1;
        check("t1_pop0_pc", bus.out_pc_o,    32'h0);
        check("t1_pop0_in", bus.out_instr_o, 32'h0010_0093);
        tick();
        check("t1_pop1_pc", bus.out_pc_o,    32'h4);
        check("t1_pop1_in", bus.out_instr_o, 32'h0020_0113);
        tick();
        check("t1_pop2_pc", bus.out_pc_o,    32'h8);
        check("t1_pop2_in", bus.out_instr_o, 32'h0030_0193);
        tick();
        bus.out_ready_i = 1'b0;
        check("t1_empty_valid", 32'(bus.out_valid_o), 32'd0);
        check("t1_empty_instr", bus.out_instr_o,      NOP);
        check("t1_empty_pc",    bus.out_pc_o,         32'h8);

        // Fill to DEPTH, drop a fifth word, free one slot.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h10 + 32'(4 * i), 32'h0000_0013 | (32'(i) << 20), 1'b0);
            tick();
        end
        check("t2_count4", 32'(count_o),         32'd4);
        check("t2_full",   32'(bus.in_ready_o),  32'd0);
        drive(1'b1, 32'h20, 32'hDEAD_BEEF, 1'b0);
        tick();
        check("t2_drop_count", 32'(count_o), 32'd4);
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        check("t2_head_pc", bus.out_pc_o, 32'h10);
        tick();
        check("t2_pop_ready", 32'(bus.in_ready_o), 32'd1);
        check("t2_pop_count", 32'(count_o),        32'd3);
        check("t2_next_pc",   bus.out_pc_o,        32'h14);
        tick();
        tick();
        check("t2_last_pc", bus.out_pc_o, 32'h1c);
        tick();
        bus.out_ready_i = 1'b0;
        check("t2_drained", 32'(count_o), 32'd0);

        // Streaming: one word in flight, pointers wrap more than once.
        drive(1'b1, 32'h100, 32'h100 ^ 32'hABC0_0003, 1'b0);
        tick();
        for (int i = 1; i < 10; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), (32'h100 + 32'(4 * i)) ^ 32'hABC0_0003, 1'b1);
            check($sformatf("t3_cnt%0d", i), 32'(count_o), 32'd1);
            check($sformatf("t3_pc%0d", i),  bus.out_pc_o, 32'h100 + 32'(4 * (i - 1)));
            check($sformatf("t3_in%0d", i),  bus.out_instr_o,
                  (32'h100 + 32'(4 * (i - 1))) ^ 32'hABC0_0003);
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        check("t3_pc_last", bus.out_pc_o,    32'h124);
        check("t3_in_last", bus.out_instr_o, 32'h124 ^ 32'hABC0_0003);
        tick();
        bus.out_ready_i = 1'b0;
        check("t3_drained", 32'(count_o), 32'd0);

        // Flush with a coincident push discards everything.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h30 + 32'(4 * i), 32'h0040_0013 + 32'(i), 1'b0);
            tick();
        end
        drive(1'b1, 32'h40, 32'h0050_0013, 1'b0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        check("t4_count", 32'(count_o),         32'd0);
        check("t4_valid", 32'(bus.out_valid_o), 32'd0);
        check("t4_instr", bus.out_instr_o,      NOP);
        drive(1'b1, 32'h200, 32'h0060_0013, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        check("t4_post_pc",    bus.out_pc_o, 32'h200);
        check("t4_post_count", 32'(count_o), 32'd1);
        tick();
        bus.out_ready_i = 1'b0;

        // Asynchronous reset with two entries queued.
        drive(1'b1, 32'h50, 32'h0070_0013, 1'b0);
        tick();
        drive(1'b1, 32'h54, 32'h0080_0013, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        check("t5_pre_count", 32'(count_o), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(bus.out_valid_o), 32'd0);
        check("t5_rst_count", 32'(count_o),         32'd0);
        check("t5_rst_pc",    bus.out_pc_o,         32'h0);
        #2 rst_n = 1'b1;
        tick();

        // Illegal-encoding flag follows the head entry.
        drive(1'b1, 32'h300, 32'h0000_0001, 1'b0);
        tick();
        drive(1'b1, 32'h304, 32'h0000_0013, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        check("t6_ill_first",  32'(bus.out_illegal_o), 32'(ILL_EXP));
        tick();
        check("t6_ill_second", 32'(bus.out_illegal_o), 32'd0);
        tick();
        bus.out_ready_i = 1'b0;
        check("t6_ill_empty",  32'(bus.out_illegal_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_ifq
